otter_uart_tx: RTL and testbench
================================

# otter_uart_tx

Memory-mapped UART transmitter that responds to the Otter MCU's IOBUS writes and reads (`IOBUS_ADDR`, `IOBUS_OUT`, `IOBUS_WR`, `IOBUS_IN`). It decodes three word registers at `BASE_ADDR` and queues written bytes in a small FIFO. A serializer FSM shifts the bytes out on `TX` as 8N1 frames at a programmable baud divisor. It sits beside the MCU at the top level, in the IO address space.

## Interface
- `BASE_ADDR`, 32'h1100_0400: word-aligned base of the 3-register window.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..64.
- `CLKS_PER_BIT`, 868: reset value of the baud divisor (100 MHz / 115200).
- `CLK` in 1: system clock, the MCU clock.
- `RESET` in 1: synchronous, active-high reset. Polarity and synchronicity are fixed.
- `IOBUS_ADDR` in 32: byte address from the MCU.
- `IOBUS_OUT` in 32: write data from the MCU.
- `IOBUS_WR` in 1: write strobe, one cycle per store.
- `IOBUS_IN` out 32: read data. Combinational from `IOBUS_ADDR`; 0 outside the window.
- `TX` out 1: serial line, idle high.
- `INTR_TX` out 1: present only with `UART_TX_INTR_EN` (see Configuration).

## Operation
- Register map, decoded on full 32-bit address equality:
  - `BASE+0` TXDATA. Write pushes `IOBUS_OUT[7:0]`. Reads return 0.
  - `BASE+4` STATUS, read-only except bit 3:
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[14:8] fill count
    - all other bits 0
    - Writing 1 to bit3 clears overflow.
  - `BASE+8` DIVISOR, 16 bits, read/write. Writing 0 stores 1.
- Writes to other addresses, or with `IOBUS_WR`=0, have no effect.
- Push when full: the byte is dropped and overflow is set. Exception: if the FSM pops in the same cycle, the push is accepted and the count is unchanged.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop into the shift register and go to START. Otherwise stay.
  - START: `TX`=0 for DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, DIV cycles each. The bit counter runs 0..7, then STOP.
  - STOP: `TX`=1 for DIV cycles. If FIFO non-empty at the last cycle, pop and go to START (no idle gap). Otherwise go to IDLE.
- Baud counter: loaded with DIV−1 at each bit start and counts down to 0. A DIVISOR write mid-frame takes effect at the next bit boundary.
- Reset values:
  - `TX`=1, `IOBUS_IN` combinational (0 for any unmapped address)
  - FIFO empty, overflow=0, DIVISOR=`CLKS_PER_BIT`, FSM IDLE
  - `INTR_TX`=0
- `RESET` mid-frame aborts the frame immediately. `TX` is high after the reset edge and queued bytes are discarded.

## Timing
- A TXDATA write on edge k makes the FIFO non-empty after edge k.
- IDLE pops on edge k+1. `TX` falls after edge k+1.
- A frame is exactly 10·DIV cycles. Back-to-back queued bytes produce contiguous frames.
- STATUS reflects state registered at the most recent edge; there is no read side effect.
- Fill count and full/empty update one edge after a push or pop.

## Configuration
- `UART_TX_INTR_EN` defined:
  - `INTR_TX` port exists.
  - It pulses high for exactly one cycle after the final STOP cycle when the FSM returns to IDLE with the FIFO empty (transmit-done interrupt for the MCU `INTR`).
  - It does not pulse on the STOP→START path. It is 0 in reset.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `otter_io_pkg`:
  - `uart_tx_state_t` enum {IDLE, START, DATA, STOP}
  - register offset constants `UART_TXDATA_OFS`=0, `UART_STATUS_OFS`=4, `UART_DIV_OFS`=8
  - STATUS bit-index constants
- Sub-module `uart_tx_fifo`: synchronous FIFO with push, pop, full, empty and count.
  - Pointers are log2(`FIFO_DEPTH`) bits with wrap-around.
  - Full/empty come from the count, not from pointer equality.
- Top level holds the address decode, DIVISOR, overflow and the serializer FSM.

## Test plan
- Reset, then DIVISOR=4, then write 0x55 → `TX` high until k+1, then the pattern 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit (40 cycles total); busy clears afterwards.
- Write 0xA5, 0x3C back-to-back, DIV=4 → two contiguous 40-cycle frames with no idle cycle; STATUS count reads 1 then 0.
- `FIFO_DEPTH`=8, DIV=1000: write 10 bytes quickly → first popped, 8 queued. STATUS full=1, overflow=1, count=8. Writing STATUS bit3=1 clears overflow.
- Mid-DATA DIVISOR write 4→8 → the current bit keeps 4 cycles, subsequent bits take 8. Writing DIVISOR=0 reads back 1.
- Assert `RESET` during DATA with 3 bytes queued → `TX`=1 next cycle, STATUS=0x4 (empty), DIVISOR back to 868.
- With `UART_TX_INTR_EN`, send 2 queued bytes → exactly one `INTR_TX` pulse, one cycle wide, after the second STOP. Reads of `BASE+12` return 0.

Source files
------------

// File: rtl/otter_io_pkg.sv
// Shared definitions for Otter IO peripherals: UART TX state encoding,
// register offsets and STATUS bit positions.
package otter_io_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    localparam logic [31:0] UART_TXDATA_OFS = 32'd0;
    localparam logic [31:0] UART_STATUS_OFS = 32'd4;
    localparam logic [31:0] UART_DIV_OFS    = 32'd8;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_CNT_LSB   = 8;
    localparam int STAT_CNT_MSB   = 14;

    function automatic logic [31:0] uart_status(input logic       busy,
                                                input logic       full,
                                                input logic       empty,
                                                input logic       ovf,
                                                input logic [6:0] cnt);
        logic [31:0] s;
        s                              = '0;
        s[STAT_BUSY_BIT]               = busy;
        s[STAT_FULL_BIT]               = full;
        s[STAT_EMPTY_BIT]              = empty;
        s[STAT_OVF_BIT]                = ovf;
        s[STAT_CNT_MSB:STAT_CNT_LSB]   = cnt;
        return s;
    endfunction

endpackage

// File: rtl/otter_uart_tx_if.sv
// Otter MCU IOBUS bundle: the MCU is the master, peripherals are slaves.
interface otter_uart_tx_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, input IOBUS_IN);
    modport slave  (input IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter. Full/empty derive from the fill count;
// the caller must never pop when empty nor push when full without a pop.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [7:0]               i_data,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // NOTE: storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/otter_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the Otter IOBUS (TXDATA/STATUS/DIVISOR).
// Define UART_TX_INTR_EN to add the one-cycle INTR_TX transmit-done pulse.
module otter_uart_tx
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0400,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic              CLK,
    input  logic              RESET,
    otter_uart_tx_if.slave    bus,
    output logic              TX
`ifdef UART_TX_INTR_EN
    ,
    output logic              INTR_TX
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    uart_tx_state_t   r_state;
    logic [15:0]      r_div;
    logic [15:0]      r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_ovf;

    logic             w_push_req, w_push, w_pop;
    logic             w_wr_status, w_wr_div, w_baud_done;
    logic             w_full, w_empty;
    logic [7:0]       w_fifo_data;
    logic [CNT_W-1:0] w_count;
    logic             w_unused_ok;

    assign w_push_req  = bus.IOBUS_WR && (bus.IOBUS_ADDR == BASE_ADDR + UART_TXDATA_OFS);
    assign w_wr_status = bus.IOBUS_WR && (bus.IOBUS_ADDR == BASE_ADDR + UART_STATUS_OFS);
    assign w_wr_div    = bus.IOBUS_WR && (bus.IOBUS_ADDR == BASE_ADDR + UART_DIV_OFS);
    assign w_baud_done = (r_baud == 16'd0);
    assign w_pop       = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));
    // A full FIFO still accepts a byte when the serializer frees a slot this cycle.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_unused_ok = ^bus.IOBUS_OUT[31:16];

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.IOBUS_OUT[7:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_div <= 16'(CLKS_PER_BIT);
            r_ovf <= 1'b0;
        end else begin
            if (w_wr_div)
                r_div <= (bus.IOBUS_OUT[15:0] == 16'd0) ? 16'd1 : bus.IOBUS_OUT[15:0];
            if (w_push_req && !w_push)
                r_ovf <= 1'b1;
            else if (w_wr_status && bus.IOBUS_OUT[STAT_OVF_BIT])
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (w_pop) begin
                    r_shift <= w_fifo_data;
                    r_baud  <= r_div - 16'd1;
                    r_tx    <= 1'b0;
                    r_state <= START;
                end
                START: if (w_baud_done) begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_bit   <= '0;
                    r_baud  <= r_div - 16'd1;
                    r_state <= DATA;
                end else r_baud <= r_baud - 16'd1;
                DATA: if (w_baud_done) begin
                    r_baud <= r_div - 16'd1;
                    if (r_bit == 3'd7) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end
                end else r_baud <= r_baud - 16'd1;
                STOP: if (w_baud_done) begin
                    if (w_pop) begin
                        r_shift <= w_fifo_data;
                        r_baud  <= r_div - 16'd1;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end else r_state <= IDLE;
                end else r_baud <= r_baud - 16'd1;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign TX = r_tx;

    // NOTE: default assignment first so no path leaves the output unassigned (no latch).
    always_comb begin
        bus.IOBUS_IN = '0;
        if (bus.IOBUS_ADDR == BASE_ADDR + UART_STATUS_OFS)
            bus.IOBUS_IN = uart_status(r_state != IDLE, w_full, w_empty, r_ovf, 7'(w_count));
        else if (bus.IOBUS_ADDR == BASE_ADDR + UART_DIV_OFS)
            bus.IOBUS_IN = {16'd0, r_div};
    end

`ifdef UART_TX_INTR_EN
    logic r_intr;

    always_ff @(posedge CLK) begin
        if (RESET) r_intr <= 1'b0;
        else       r_intr <= (r_state == STOP) && w_baud_done && w_empty;
    end

    assign INTR_TX = r_intr;
`endif
endmodule

// File: tb/tb_otter_uart_tx.sv
// Self-checking bench for otter_uart_tx: directed scenarios plus random IOBUS
// traffic, compared cycle by cycle against a frame-level reference model.
module tb_otter_uart_tx;
    localparam logic [31:0] A_TX  = 32'h1100_0400;
    localparam logic [31:0] A_ST  = 32'h1100_0404;
    localparam logic [31:0] A_DIV = 32'h1100_0408;
    localparam logic [31:0] A_BAD = 32'h1100_040C;
    localparam int          DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;
`ifdef UART_TX_INTR_EN
    logic intr;
    int   n_intr;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    otter_uart_tx_if iob();

    otter_uart_tx dut (
        .CLK     (clk),
        .RESET   (rst),
        .bus     (iob),
        .TX      (tx)
`ifdef UART_TX_INTR_EN
        ,
        .INTR_TX (intr)
`endif
    );

    // Reference model: a queue of bytes and the frame currently on the wire,
    // described as a 10-bit word {stop, data, start} with per-bit cycle budget.
    byte unsigned m_q[$];
    bit           m_active;
    logic [9:0]   m_frame;
    int           m_bit;
    int           m_left;
    int           m_div;
    bit           m_ovf;
    bit           m_intr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_frame  = '1;
        m_bit    = 0;
        m_left   = 0;
        m_div    = 868;
        m_ovf    = 1'b0;
        m_intr   = 1'b0;
    endfunction

    function automatic void start_frame();
        byte unsigned b;
        b        = m_q.pop_front();
        m_frame  = {1'b1, b, 1'b0};
        m_bit    = 0;
        m_left   = m_div;
        m_active = 1'b1;
    endfunction

    function automatic void model_step(input logic r, input logic [31:0] a,
                                       input logic [31:0] d, input logic w);
        if (r) begin
            model_reset();
            return;
        end
        m_intr = 1'b0;
        if (m_active) begin
            if (m_left > 1)       m_left--;
            else if (m_bit < 9) begin
                m_bit++;
                m_left = m_div;
            end else if (m_q.size() > 0) start_frame();
            else begin
                m_active = 1'b0;
                m_intr   = 1'b1;
            end
        end else if (m_q.size() > 0) start_frame();
        if (w) begin
            if (a == A_TX) begin
                if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
                else                    m_ovf = 1'b1;
            end else if (a == A_ST) begin
                if (d[3]) m_ovf = 1'b0;
            end else if (a == A_DIV) begin
                m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
            end
        end
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = m_active;
        s[1]     = (m_q.size() == DEPTH);
        s[2]     = (m_q.size() == 0);
        s[3]     = m_ovf;
        s[14:8]  = 7'(m_q.size());
        return s;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a == A_ST)  return exp_status();
        if (a == A_DIV) return 32'(m_div);
        return 32'd0;
    endfunction

    function automatic logic exp_tx();
        return m_active ? m_frame[m_bit] : 1'b1;
    endfunction

    // One clock: drive inputs, advance the model at the edge, check on the falling edge.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic r = 1'b0);
        iob.IOBUS_ADDR = a;
        iob.IOBUS_OUT  = d;
        iob.IOBUS_WR   = w;
        rst            = r;
        @(posedge clk);
        model_step(r, a, d, w);
        @(negedge clk);
        check("tx", 32'(tx), 32'(exp_tx()));
`ifdef UART_TX_INTR_EN
        check("intr", 32'(intr), 32'(m_intr));
        if (intr === 1'b1) n_intr++;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(32'd0, 32'd0, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        iob.IOBUS_ADDR = a;
        iob.IOBUS_WR   = 1'b0;
        #1;
        check(tag, iob.IOBUS_IN, exp_read(a));
        cyc(a, 32'd0, 1'b0);
    endtask

    task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] exp);
        iob.IOBUS_ADDR = a;
        iob.IOBUS_WR   = 1'b0;
        #1;
        check(tag, iob.IOBUS_IN, exp);
        cyc(a, 32'd0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lows;
        int op;
        logic [31:0] addr;
        model_reset();
`ifdef UART_TX_INTR_EN
        n_intr = 0;
`endif
        iob.IOBUS_ADDR = '0;
        iob.IOBUS_OUT  = '0;
        iob.IOBUS_WR   = 1'b0;

        // Reset state.
        cyc(32'd0, 32'd0, 1'b0, 1'b1);
        cyc(32'd0, 32'd0, 1'b0, 1'b1);
        rd_exp("rst_status", A_ST, 32'h4);
        rd_exp("rst_div", A_DIV, 32'd868);
        rd_exp("rst_unmapped", A_BAD, 32'd0);
        rd_exp("rst_txdata", A_TX, 32'd0);

        // Single 0x55 frame at DIV=4: 5 low bits of 4 cycles each.
        cyc(A_DIV, 32'd4, 1'b1);
        cyc(A_TX, 32'h55, 1'b1);
        lows = 0;
        for (int i = 0; i < 45; i++) begin
            cyc(32'd0, 32'd0, 1'b0);
            if (tx === 1'b0) lows++;
        end
        check("t1_low_cycles", 32'(lows), 32'd20);
        rd_exp("t1_status_idle", A_ST, 32'h4);

        // Back-to-back bytes: count 1 during first frame, 0 once second starts.
        cyc(A_TX, 32'hA5, 1'b1);
        cyc(A_TX, 32'h3C, 1'b1);
        rd_exp("t2_status_cnt1", A_ST, 32'h101);
        idle(40);
        rd_exp("t2_status_cnt0", A_ST, 32'h5);
        idle(45);
        rd_exp("t2_status_idle", A_ST, 32'h4);

        // Overflow with a slow divisor.
        cyc(A_DIV, 32'd1000, 1'b1);
        for (int i = 0; i < 10; i++) cyc(A_TX, 32'($urandom_range(0, 255)), 1'b1);
        rd_exp("t3_status_full_ovf", A_ST, 32'h80B);
        cyc(A_ST, 32'hFFFF_FFF7, 1'b1);
        rd_exp("t3_ovf_kept", A_ST, 32'h80B);
        cyc(A_ST, 32'h8, 1'b1);
        rd_exp("t3_ovf_cleared", A_ST, 32'h803);
        cyc(32'd0, 32'd0, 1'b0, 1'b1);

        // Divisor 4 -> 8 during data bit 0 of 0xF0.
        cyc(A_DIV, 32'd4, 1'b1);
        cyc(A_TX, 32'hF0, 1'b1);
        lows = 0;
        for (int i = 0; i < 90; i++) begin
            if (i == 6) cyc(A_DIV, 32'd8, 1'b1);
            else        cyc(32'd0, 32'd0, 1'b0);
            if (tx === 1'b0) lows++;
        end
        check("t4_low_cycles", 32'(lows), 32'd32);
        cyc(A_DIV, 32'd0, 1'b1);
        rd_exp("t4_div_zero", A_DIV, 32'd1);

        // Reset in the middle of DATA with three bytes queued.
        cyc(A_DIV, 32'd4, 1'b1);
        for (int i = 0; i < 4; i++) cyc(A_TX, 32'h0F + 32'(i), 1'b1);
        idle(8);
        cyc(32'd0, 32'd0, 1'b0, 1'b1);
        check("t5_tx_after_reset", 32'(tx), 32'd1);
        rd_exp("t5_status", A_ST, 32'h4);
        rd_exp("t5_div", A_DIV, 32'd868);
        idle(20);

        // Random IOBUS traffic with small divisors.
        cyc(A_DIV, 32'd2, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            op = int'($urandom_range(0, 19));
            if (op < 6)        cyc(A_TX, $urandom, 1'b1);
            else if (op == 6)  cyc(A_ST, $urandom, 1'b1);
            else if (op == 7)  cyc(A_DIV, 32'($urandom_range(0, 5)), 1'b1);
            else if (op < 11) begin
                case ($urandom_range(0, 4))
                    0:       addr = A_TX;
                    1:       addr = A_ST;
                    2:       addr = A_DIV;
                    3:       addr = A_BAD;
                    default: addr = $urandom;
                endcase
                rd("rand_read", addr);
            end else if (op == 11) cyc($urandom, $urandom, 1'b1);
            else               cyc(32'd0, 32'd0, 1'b0);
        end
        cyc(A_DIV, 32'd2, 1'b1);
        idle(300);
        rd("rand_drained_status", A_ST);

        // Transmit-done pulse after two queued bytes.
        cyc(32'd0, 32'd0, 1'b0, 1'b1);
        cyc(A_DIV, 32'd2, 1'b1);
`ifdef UART_TX_INTR_EN
        n_intr = 0;
`endif
        cyc(A_TX, 32'h12, 1'b1);
        cyc(A_TX, 32'h34, 1'b1);
        idle(60);
`ifdef UART_TX_INTR_EN
        check("t7_intr_pulses", 32'(n_intr), 32'd1);
`endif
        rd_exp("t7_base12", A_BAD, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
